mod_add_sched: RTL and testbench

MOD_ADD_SCHED -- requirements
Module: mod_add_sched

---
 rtl/mod_add_sched.sv | 120 ++++++++++++
 tb/tb_mod_add_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_add_sched.sv
// Two-requester round-robin adder that ripples one shared 4-bit slice over NIBBLES cycles.
// Latency: ack registered at grant edge T, o_valid high after edge T+NIBBLES+1; one op per NIBBLES+2 cycles.
// Backpressure: requests are held until acked; no grants while busy, so late requests simply wait.
module mod_add_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req0,
    input  logic                   i_req1,
    input  logic [4*NIBBLES-1:0]   i_a0,
    input  logic [4*NIBBLES-1:0]   i_b0,
    input  logic [4*NIBBLES-1:0]   i_a1,
    input  logic [4*NIBBLES-1:0]   i_b1,
    output logic                   o_ack0,
    output logic                   o_ack1,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic                   o_id,
    output logic [4*NIBBLES-1:0]   o_sum,
    output logic                   o_carry
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_q, b_q, sum_w, sum_nx;
    logic [CW-1:0] cnt;
    logic          carry_q, id_q, last_q;
    logic          gnt0, gnt1;
    logic [3:0]    a_nib, b_nib;
    logic [4:0]    slice;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        a_nib    = 4'd0;
        b_nib    = 4'd0;
        sum_nx   = sum_w;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) sum_nx[4*i +: 4] = slice[3:0];
        end
        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    // last_q==1 means requester 1 was served last, so a tie goes to 0
                    gnt1     = i_req1 && (!i_req0 || !last_q);
                    gnt0     = !gnt1;
                    state_nx = ADD;
                end
            end
            ADD:     if (cnt == CW'(NIBBLES - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            sum_w   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            o_ack0  <= 1'b0;
            o_ack1  <= 1'b0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_id    <= 1'b0;
            o_sum   <= '0;
            o_carry <= 1'b0;
        end else begin
            o_ack0  <= gnt0;
            o_ack1  <= gnt1;
            o_busy  <= (state_nx != IDLE);
            o_valid <= (state == DONE);
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q     <= gnt1 ? i_a1 : i_a0;
                        b_q     <= gnt1 ? i_b1 : i_b0;
                        id_q    <= gnt1;
                        last_q  <= gnt1;
                        carry_q <= 1'b0;
                        cnt     <= '0;
                    end
                end
                ADD: begin
                    sum_w   <= sum_nx;
                    carry_q <= slice[4];
                    if (cnt != CW'(NIBBLES - 1)) cnt <= cnt + CW'(1);
                end
                DONE: begin
                    // Result registers only move here, so partial sums never leak out
                    o_sum   <= sum_w;
                    o_carry <= carry_q;
                    o_id    <= id_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_add_sched.sv
// Self-checking bench for mod_add_sched (NIBBLES=4): vector table, scoreboard monitor, directed corner sequences.
module tb_mod_add_sched;
    localparam int NIBBLES = 4;

    logic        clk;
    logic        i_rst, i_req0, i_req1;
    logic [15:0] i_a0, i_b0, i_a1, i_b1;
    logic        o_ack0, o_ack1, o_busy, o_valid, o_id, o_carry;
    logic [15:0] o_sum;

    typedef struct {
        logic        r0, r1;
        logic [15:0] a0, b0, a1, b1;
        logic        exp_id;
        logic [15:0] exp_sum;
        logic        exp_c;
    } vec_t;

    typedef struct packed {
        logic        id;
        logic [15:0] sum;
        logic        c;
    } res_t;

    res_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] held_sum = 16'h0;

    mod_add_sched #(.NIBBLES(NIBBLES)) dut (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_req0 (i_req0),
        .i_req1 (i_req1),
        .i_a0   (i_a0),
        .i_b0   (i_b0),
        .i_a1   (i_a1),
        .i_b1   (i_b1),
        .o_ack0 (o_ack0),
        .o_ack1 (o_ack1),
        .o_busy (o_busy),
        .o_valid(o_valid),
        .o_id   (o_id),
        .o_sum  (o_sum),
        .o_carry(o_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every o_valid pops one expected result
    always begin
        res_t e;
        @(posedge clk);
        #1;
        if (o_ack0 || o_ack1) chk("ack overlap", {31'd0, o_ack0 & o_ack1}, 32'd0);
        if (o_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected valid: got o_valid=1 with id=%0d sum=0x%0h, expected no result", o_id, o_sum);
            end else begin
                e = sb.pop_front();
                chk("result id", {31'd0, o_id}, {31'd0, e.id});
                chk("result sum", {16'd0, o_sum}, {16'd0, e.sum});
                chk("result carry", {31'd0, o_carry}, {31'd0, e.c});
                held_sum = e.sum;
            end
        end
    end

    task automatic do_reset();
        i_rst  = 1'b1;
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        tick();
        tick();
        i_rst    = 1'b0;
        held_sum = 16'h0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k;
        bit got;
        i_req0 = v.r0; i_req1 = v.r1;
        i_a0 = v.a0; i_b0 = v.b0; i_a1 = v.a1; i_b1 = v.b1;
        got = 0;
        for (k = 0; k < 20; k++) begin
            tick();
            if (o_ack0 || o_ack1) begin
                got = 1;
                break;
            end
        end
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        if (!got) begin
            chk({tag, " ack timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, " ack id"}, {31'd0, o_ack1}, {31'd0, v.exp_id});
        sb.push_back('{v.exp_id, v.exp_sum, v.exp_c});
        for (k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) begin
                chk({tag, " busy in ADD"}, {31'd0, o_busy}, 32'd1);
                chk({tag, " sum held in ADD"}, {16'd0, o_sum}, {16'd0, held_sum});
            end
            if (o_valid) break;
        end
        chk({tag, " latency"}, k, NIBBLES + 1);
        tick();
        chk({tag, " scoreboard drained"}, sb.size(), 32'd0);
    endtask

    initial begin
        vec_t        tbl[7];
        vec_t        v;
        logic [16:0] s;
        int          k, gap, cnt_v;
        bit          got, saw1;

        tbl[0] = '{1'b1, 1'b0, 16'h1234, 16'h4321, 16'h0000, 16'h0000, 1'b0, 16'h5555, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0F0F, 16'h00F1, 1'b1, 16'h1000, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 16'hABCD, 16'h1111, 16'h0001, 16'h0002, 1'b0, 16'hBCDE, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h8000, 1'b0};

        i_rst = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0;
        i_a0 = '0; i_b0 = '0; i_a1 = '0; i_b1 = '0;
        do_reset();
        chk("reset ack0", {31'd0, o_ack0}, 32'd0);
        chk("reset ack1", {31'd0, o_ack1}, 32'd0);
        chk("reset busy", {31'd0, o_busy}, 32'd0);
        chk("reset valid", {31'd0, o_valid}, 32'd0);
        chk("reset sum", {16'd0, o_sum}, 32'd0);
        chk("reset carry", {31'd0, o_carry}, 32'd0);
        chk("reset id", {31'd0, o_id}, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            v.r0 = (i % 2) == 1;
            v.r1 = !v.r0;
            v.a0 = 16'($urandom_range(0, 65535)); v.b0 = 16'($urandom_range(0, 65535));
            v.a1 = 16'($urandom_range(0, 65535)); v.b1 = 16'($urandom_range(0, 65535));
            v.exp_id = v.r1;
            s = v.r1 ? ({1'b0, v.a1} + {1'b0, v.b1}) : ({1'b0, v.a0} + {1'b0, v.b0});
            v.exp_sum = s[15:0];
            v.exp_c   = s[16];
            run_vec(v, $sformatf("rand%0d", i));
        end

        // Both requests held: strict alternation starting with 0 after reset
        do_reset();
        i_a0 = 16'h0001; i_b0 = 16'h0002; i_a1 = 16'h0010; i_b1 = 16'h0020;
        i_req0 = 1'b1; i_req1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (gap = 1; gap <= 20; gap++) begin
                tick();
                if (o_ack0 || o_ack1) begin
                    got = 1;
                    break;
                end
            end
            if (!got) begin
                chk($sformatf("rr grant%0d timeout", g), 32'd0, 32'd1);
                break;
            end
            chk($sformatf("rr grant%0d id", g), {31'd0, o_ack1}, g % 2);
            if (g > 0) chk($sformatf("rr grant%0d spacing", g), gap, NIBBLES + 2);
            if (g % 2 == 0) sb.push_back('{1'b0, 16'h0003, 1'b0});
            else            sb.push_back('{1'b1, 16'h0030, 1'b0});
        end
        i_req0 = 1'b0; i_req1 = 1'b0;
        for (k = 0; k < 20 && sb.size() != 0; k++) tick();
        tick();
        chk("rr scoreboard drained", sb.size(), 32'd0);

        // Reset during ADD cycle 2 aborts the requester-1 operation
        i_req1 = 1'b1; i_a1 = 16'h8000; i_b1 = 16'h8000;
        got = 0;
        for (k = 0; k < 20; k++) begin
            tick();
            if (o_ack1) begin
                got = 1;
                break;
            end
        end
        i_req1 = 1'b0;
        chk("abort ack1 seen", {31'd0, got}, 32'd1);
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("abort busy cleared", {31'd0, o_busy}, 32'd0);
        chk("abort valid cleared", {31'd0, o_valid}, 32'd0);
        held_sum = 16'h0;
        cnt_v = 0;
        for (k = 0; k < 10; k++) begin
            tick();
            if (o_valid) cnt_v++;
        end
        chk("abort no valid", cnt_v, 32'd0);
        v = '{1'b1, 1'b1, 16'h0102, 16'h0304, 16'h8000, 16'h8000, 1'b0, 16'h0406, 1'b0};
        run_vec(v, "post-abort");

        // Short req1 pulse while busy must be ignored
        i_req0 = 1'b1; i_a0 = 16'h1111; i_b0 = 16'h2222;
        got = 0;
        for (k = 0; k < 20; k++) begin
            tick();
            if (o_ack0) begin
                got = 1;
                break;
            end
        end
        i_req0 = 1'b0;
        chk("pulse ack0 seen", {31'd0, got}, 32'd1);
        if (got) sb.push_back('{1'b0, 16'h3333, 1'b0});
        saw1 = 0;
        tick();
        chk("pulse busy before req1", {31'd0, o_busy}, 32'd1);
        i_req1 = 1'b1; i_a1 = 16'hFFFF; i_b1 = 16'hFFFF;
        tick();
        if (o_ack1) saw1 = 1;
        i_req1 = 1'b0;
        for (k = 0; k < 15; k++) begin
            tick();
            if (o_ack1) saw1 = 1;
        end
        chk("pulse no ack1", {31'd0, saw1}, 32'd0);
        chk("pulse sum held", {16'd0, o_sum}, 32'h3333);
        chk("pulse valid low", {31'd0, o_valid}, 32'd0);
        chk("pulse scoreboard drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
